// File: rtl/timer_six.sv
// Modulo-(MAX+1) down-counting timer digit with sync clear, saturating load and enable; borrow on wrap.
// Latency: load/decrement take 1 cycle, tc/zero are combinational; no backpressure, so en is always accepted.
module timer_six #(
    parameter int unsigned MAX = 5,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] in,
    input  logic         loadn,
    input  logic         en,
    output logic [W-1:0] out,
    output logic         tc,
    output logic         zero
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            count <= '0;
        end else if (!loadn) begin
            // Out-of-range BCD loads clamp to the top of the digit range
            count <= (in > MAX_V) ? MAX_V : in;
        end else if (en) begin
            count <= (count == '0) ? MAX_V : count - W'(1);
        end
    end

    assign out  = count;
    assign zero = (count == '0);
    assign tc   = en & zero;

endmodule

// File: tb/tb_timer_six.sv
// Directed bench for timer_six: reset, load/count, reloads, clear priority, saturating load, load over enable.
module tb_timer_six;

    logic       clk;
    logic       clrn;
    logic [3:0] in;
    logic       loadn;
    logic       en;
    logic [3:0] out;
    logic       tc;
    logic       zero;

    int n_checks = 0;
    int n_fail   = 0;

    timer_six #(.MAX(5), .W(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .in   (in),
        .loadn(loadn),
        .en   (en),
        .out  (out),
        .tc   (tc),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before inspecting outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v, input int exp_out);
        in    = 4'(v);
        loadn = 1'b0;
        en    = 1'b0;
        tick();
        loadn = 1'b1;
        #1;
        check("load_out", int'(out), exp_out);
        check("load_zero", int'(zero), (exp_out == 0) ? 1 : 0);
    endtask

    // Run n enabled edges from the current digit value, checking the full 5..0 wrap.
    task automatic run_enabled(input int start, input int n);
        int exp;
        int wraps;
        int exp_wraps;
        exp       = start;
        wraps     = 0;
        exp_wraps = (n > start) ? 1 + (n - start - 1) / 6 : 0;
        en        = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("cnt_tc", int'(tc), (exp == 0) ? 1 : 0);
            check("cnt_zero", int'(zero), (exp == 0) ? 1 : 0);
            if (tc) wraps++;
            tick();
            exp = (exp == 0) ? 5 : exp - 1;
            check("cnt_out", int'(out), exp);
        end
        check("cnt_wraps", wraps, exp_wraps);
        en = 1'b0;
    endtask

    initial begin
        clrn  = 1'b0;
        loadn = 1'b1;
        en    = 1'b0;
        in    = 4'd0;

        // Reset
        tick();
        check("rst_out", int'(out), 0);
        check("rst_zero", int'(zero), 1);
        check("rst_tc", int'(tc), 0);
        en = 1'b1;
        #1;
        check("rst_tc_en", int'(tc), 1);
        en   = 1'b0;
        clrn = 1'b1;

        // Load 5 and count through one wrap
        do_load(5, 5);
        run_enabled(5, 8);

        // Reloads
        do_load(4, 4);
        run_enabled(4, 8);
        do_load(2, 2);
        run_enabled(2, 8);
        do_load(1, 1);
        run_enabled(1, 8);

        // Clear beats load, and held clear pins the digit at 0
        do_load(4, 4);
        in    = 4'd3;
        loadn = 1'b0;
        clrn  = 1'b0;
        tick();
        check("clr_pri_out", int'(out), 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clr_hold_out", int'(out), 0);
            check("clr_hold_zero", int'(zero), 1);
            check("clr_hold_tc", int'(tc), 1);
        end
        en    = 1'b0;
        loadn = 1'b1;
        clrn  = 1'b1;

        // Saturating load, then hold with en low
        do_load(9, 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_out", int'(out), 5);
            check("hold_tc", int'(tc), 0);
            check("hold_zero", int'(zero), 0);
        end
        do_load(15, 5);

        // Load wins over enable at count 0
        do_load(0, 0);
        in    = 4'd3;
        loadn = 1'b0;
        en    = 1'b1;
        #1;
        check("lde_tc", int'(tc), 1);
        tick();
        check("lde_out", int'(out), 3);
        loadn = 1'b1;
        en    = 1'b0;

        // Clear mid-count, then resume from 0 which wraps to 5
        en = 1'b1;
        tick();
        check("mid_dec", int'(out), 2);
        clrn = 1'b0;
        tick();
        check("mid_clr", int'(out), 0);
        clrn = 1'b1;
        tick();
        check("mid_wrap", int'(out), 5);
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
